ahb_sram_sub: RTL and testbench
===============================

Name: ahb_sram_sub

Overview:
Synthesisable AHB subordinate wrapping a byte-lane-writable SRAM array. It sits directly downstream of ahb_manager on the AHB bus and consumes its address and data phases. It returns OKAY, ERROR or RETRY responses, with programmable wait states, so the manager's pipeline, error and retry paths are exercised against real RTL rather than a behavioural model.

Parameters:
DATA_WDT, 32, data bus width in bits (32 or 64).
MEM_DEPTH, 256, number of DATA_WDT-wide words; byte address range is 0 .. MEM_DEPTH*DATA_WDT/8-1.
WAIT_STATES, 0, number of o_hready=0 cycles inserted before an OKAY data phase completes (0..15).

Ports:
i_hclk  in  1  clock
i_hreset_n  in  1  asynchronous, active-low reset
i_hsel  in  1  subordinate select for the current address phase
i_haddr  in  32  byte address (already base-relative)
i_htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
i_hwrite  in  1  1 = write
i_hsize  in  3  transfer size, W8=0 .. W1024=7
i_hburst  in  3  burst type; informational only, ignored
i_hwdata  in  DATA_WDT  write data, valid in the data phase
i_hready  in  1  bus HREADY; address phase is sampled only when this is 1
o_hrdata  out  DATA_WDT  read data
o_hready  out  1  subordinate ready
o_hresp  out  2  OKAY=0, ERROR=1, RETRY=2 (SPLIT=3 is never driven)
i_retry_req  in  1  when 1 at an accepted address phase, that transfer gets a RETRY

Behaviour:
- Clock and reset: clock is i_hclk; reset is i_hreset_n, asynchronous, active-low.
- Reset values: o_hready=1, o_hresp=OKAY, o_hrdata=0, FSM=IDLE, all captured address-phase registers 0. Memory contents are not reset.
- Accepting an address phase: accept when i_hsel & i_hready & i_htrans is NONSEQ or SEQ. Capture addr, write, size and lane mask.
- IDLE, BUSY, or i_hsel=0 with i_hready=1: the next cycle is a zero-wait OKAY with no memory access.
- Error checks at accept, ERROR if any is true:
  - addr >= MEM_DEPTH*DATA_WDT/8;
  - 8<<size > DATA_WDT;
  - addr not aligned to the size.
- Priority at accept: ERROR > RETRY (i_retry_req) > OKAY.
- FSM states: IDLE, WAIT, DATA, RESP1, RESP2.
  - IDLE: on accept with OKAY and WAIT_STATES>0 -> WAIT; with WAIT_STATES=0 -> DATA; ERROR/RETRY -> RESP1.
  - WAIT: o_hready=0, o_hresp=OKAY; a counter runs WAIT_STATES cycles, then -> DATA.
  - DATA: o_hready=1, o_hresp=OKAY; the transfer completes this cycle. A new accept in the same cycle is evaluated exactly as from IDLE (back-to-back pipelining); otherwise -> IDLE.
  - RESP1: o_hready=0, o_hresp=ERROR/RETRY -> RESP2.
  - RESP2: o_hready=1, same o_hresp. The address phase on the bus this cycle is accepted or ignored as from IDLE; a manager that drives IDLE here cancels cleanly.
- Writes:
  - Commit at the rising edge ending the DATA cycle, using i_hwdata, only to the byte lanes in the mask.
  - Little-endian lanes: lane index = addr[log2(DATA_WDT/8)-1:0]; W8 = 1 lane, W16 = 2 lanes, W32 = 4 lanes, and so on.
  - ERROR/RETRY transfers never write memory.
- Reads:
  - In the DATA cycle o_hrdata = full word mem[addr / (DATA_WDT/8)]; the manager selects lanes.
  - o_hrdata=0 in every other state.
  - A read whose address phase coincides with the DATA cycle of a write to the same word returns the new data. This is guaranteed because the write commits before the read's DATA cycle.
- Reset mid-transfer: FSM returns to IDLE immediately; any uncommitted write is dropped; outputs take their reset values.
- i_hburst is ignored: wrap and incr address sequencing is the manager's responsibility.

Test Plan:
1. WAIT_STATES=0: write NONSEQ W32 addr 0x10 data 0xA5A5_0001, then read 0x10 -> hready=1 on every cycle, read DATA cycle o_hrdata=0xA5A5_0001, hresp=OKAY.
2. Byte and halfword lanes: W32 write 0x0 data 0x1122_3344; W8 write addr 0x1 data 0x0000_BB00; W16 write addr 0x2 data 0xCCDD_0000; read 0x0 -> 0xCCDD_BB44.
3. Error paths: read addr MEM_DEPTH*4 -> exactly one cycle hready=0/ERROR, then one cycle hready=1/ERROR; misaligned W32 at 0x2 gives the same ERROR sequence. Memory unchanged in both cases.
4. i_retry_req=1 on a write to 0x8 -> RESP1 then RESP2 RETRY, no write; the manager reissues with retry=0 -> OKAY, and a later read of 0x8 returns the written value.
5. WAIT_STATES=3: INCR4 write burst 0x20..0x2C followed by a read burst -> each beat shows exactly 3 cycles hready=0 then 1 cycle hready=1; read data matches the written data.
6. Assert i_hreset_n=0 during the WAIT state of a write -> o_hready=1, o_hresp=OKAY, o_hrdata=0 asynchronously; the target word is not modified.

Source files
------------

// File: rtl/ahb_sram_sub_if.sv
// AHB bus bundle between a manager and the SRAM subordinate.
// The hready field is the shared bus HREADY; hready_out is the subordinate's own ready.
interface ahb_sram_sub_if #(
  parameter int DATA_WDT = 32
);
  logic                hsel;
  logic [31:0]         haddr;
  logic [1:0]          htrans;
  logic                hwrite;
  logic [2:0]          hsize;
  logic [2:0]          hburst;
  logic [DATA_WDT-1:0] hwdata;
  logic                hready;
  logic                retry_req;
  logic [DATA_WDT-1:0] hrdata;
  logic                hready_out;
  logic [1:0]          hresp;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready, retry_req,
    input  hrdata, hready_out, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready, retry_req,
    output hrdata, hready_out, hresp
  );
endinterface

// File: rtl/ahb_sram_sub.sv
// AHB subordinate over a byte-lane-writable SRAM with OKAY/ERROR/RETRY responses
// and a programmable number of wait states before each OKAY data phase.
//
// state   | meaning
// IDLE    | no transfer in its data phase
// WAIT    | OKAY transfer stalled, hready low, wait counter running
// DATA    | OKAY data phase completes; writes commit at the closing edge
// RESP1   | first ERROR/RETRY cycle, hready low
// RESP2   | second ERROR/RETRY cycle, hready high
module ahb_sram_sub #(
  parameter int DATA_WDT    = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input logic           i_hclk,
  input logic           i_hreset_n,
  ahb_sram_sub_if.slave bus
);
  localparam int          NBYTES    = DATA_WDT / 8;
  localparam int          LB        = $clog2(NBYTES);
  localparam int          AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [31:0] MEM_BYTES = 32'(MEM_DEPTH * NBYTES);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  localparam logic [1:0] RESP_OKAY  = 2'd0;
  localparam logic [1:0] RESP_ERROR = 2'd1;
  localparam logic [1:0] RESP_RETRY = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_RESP1, S_RESP2} state_t;

  state_t              state, state_nxt;
  logic [3:0]          wait_cnt, wait_cnt_nxt;
  logic [AW-1:0]       word_q;
  logic                write_q;
  logic [NBYTES-1:0]   mask_q;
  logic [1:0]          resp_q;
  logic [DATA_WDT-1:0] mem [MEM_DEPTH];

  logic              accept;
  logic              range_err, size_err, align_err;
  logic [1:0]        acc_resp;
  logic [NBYTES-1:0] lane_mask;
  logic [LB-1:0]     lane_off;
  logic              unused_sig;

  assign unused_sig = ^{bus.hburst, bus.htrans[0]};

  // Address phases are only considered in cycles where the bus could complete one.
  assign accept = bus.hsel & bus.hready & bus.htrans[1] &
                  ((state == S_IDLE) | (state == S_DATA) | (state == S_RESP2));

  assign range_err = (bus.haddr >= MEM_BYTES);
  assign size_err  = ((32'd8 << bus.hsize) > 32'(DATA_WDT));
  assign align_err = ((bus.haddr & ((32'd1 << bus.hsize) - 32'd1)) != 32'd0);
  assign lane_off  = bus.haddr[LB-1:0];

  always_comb begin
    acc_resp = RESP_OKAY;
    if (range_err || size_err || align_err) acc_resp = RESP_ERROR;
    else if (bus.retry_req)                 acc_resp = RESP_RETRY;
  end

  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < NBYTES; i++)
      lane_mask[i] = (i >= int'(lane_off)) && (i < int'(lane_off) + (1 << bus.hsize));
  end

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      S_WAIT: begin
        if (wait_cnt == 4'd0) state_nxt = S_DATA;
        else                  wait_cnt_nxt = wait_cnt - 4'd1;
      end
      S_RESP1: state_nxt = S_RESP2;
      default: begin
        state_nxt = S_IDLE;
        if (accept) begin
          if (acc_resp != RESP_OKAY) begin
            state_nxt = S_RESP1;
          end else if (WAIT_STATES > 0) begin
            state_nxt    = S_WAIT;
            wait_cnt_nxt = WAIT_LOAD;
          end else begin
            state_nxt = S_DATA;
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      word_q  <= '0;
      write_q <= 1'b0;
      mask_q  <= '0;
      resp_q  <= RESP_OKAY;
    end else if (accept) begin
      word_q  <= bus.haddr[LB +: AW];
      write_q <= bus.hwrite;
      mask_q  <= lane_mask;
      resp_q  <= acc_resp;
    end
  end

  // Memory is not reset; an async reset moves the FSM out of DATA so pending writes drop.
  always_ff @(posedge i_hclk) begin
    if (state == S_DATA && write_q) begin
      for (int b = 0; b < NBYTES; b++)
        if (mask_q[b]) mem[word_q][8*b +: 8] <= bus.hwdata[8*b +: 8];
    end
  end

  always_comb begin
    bus.hready_out = !((state == S_WAIT) || (state == S_RESP1));
    bus.hresp      = RESP_OKAY;
    bus.hrdata     = '0;
    if (state == S_RESP1 || state == S_RESP2) bus.hresp  = resp_q;
    if (state == S_DATA && !write_q)          bus.hrdata = mem[word_q];
  end
endmodule

// File: tb/tb_ahb_sram_sub.sv
// Directed bench for ahb_sram_sub: a zero-wait and a three-wait instance share one
// manager driver; a select bit routes the transfer to one of them.
module tb_ahb_sram_sub;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ahb_sram_sub_if #(.DATA_WDT(32)) bus0 ();
  ahb_sram_sub_if #(.DATA_WDT(32)) bus3 ();

  ahb_sram_sub #(.DATA_WDT(32), .MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
    .i_hclk(clk), .i_hreset_n(rst_n), .bus(bus0.slave));
  ahb_sram_sub #(.DATA_WDT(32), .MEM_DEPTH(256), .WAIT_STATES(3)) dut3 (
    .i_hclk(clk), .i_hreset_n(rst_n), .bus(bus3.slave));

  logic        use3, hsel, hwrite, retry_req;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;

  assign bus0.hsel = hsel & ~use3;   assign bus3.hsel = hsel & use3;
  assign bus0.haddr = haddr;         assign bus3.haddr = haddr;
  assign bus0.htrans = htrans;       assign bus3.htrans = htrans;
  assign bus0.hwrite = hwrite;       assign bus3.hwrite = hwrite;
  assign bus0.hsize = hsize;         assign bus3.hsize = hsize;
  assign bus0.hburst = hburst;       assign bus3.hburst = hburst;
  assign bus0.hwdata = hwdata;       assign bus3.hwdata = hwdata;
  assign bus0.retry_req = retry_req; assign bus3.retry_req = retry_req;
  assign bus0.hready = bus0.hready_out;
  assign bus3.hready = bus3.hready_out;

  wire        obs_hready = use3 ? bus3.hready_out : bus0.hready_out;
  wire [1:0]  obs_hresp  = use3 ? bus3.hresp : bus0.hresp;
  wire [31:0] obs_hrdata = use3 ? bus3.hrdata : bus0.hrdata;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic        q_wr[8];
  logic [31:0] q_addr[8], q_wdata[8], q_rdata[8];
  logic [2:0]  q_size[8];
  logic [1:0]  q_resp[8], q_wresp[8];
  int          q_waits[8];

  task automatic set_beat(input int b, input logic wr, input logic [31:0] a,
                          input logic [2:0] sz, input logic [31:0] d);
    q_wr[b] = wr; q_addr[b] = a; q_size[b] = sz; q_wdata[b] = d;
  endtask

  // Pipelined sequence: beat b+1's address phase overlaps beat b's data phase.
  task automatic run_seq(input int n, input logic retry);
    logic done;
    hsel = 1'b1; htrans = 2'd2; hburst = (n == 4) ? 3'd3 : 3'd0;
    haddr = q_addr[0]; hwrite = q_wr[0]; hsize = q_size[0]; retry_req = retry;
    @(posedge clk); #1;
    for (int b = 0; b < n; b++) begin
      if (b + 1 < n) begin
        htrans = 2'd3; haddr = q_addr[b+1]; hwrite = q_wr[b+1]; hsize = q_size[b+1];
      end else begin
        hsel = 1'b0; htrans = 2'd0; retry_req = 1'b0;
      end
      hwdata = q_wdata[b];
      q_waits[b] = 0; q_wresp[b] = 2'd0; q_rdata[b] = '0; q_resp[b] = 2'd0;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
        @(negedge clk);
        if (obs_hready) begin
          q_rdata[b] = obs_hrdata; q_resp[b] = obs_hresp; done = 1'b1;
        end else begin
          if (q_waits[b] == 0) q_wresp[b] = obs_hresp;
          q_waits[b]++;
        end
      end
      if (!done) check_val("beat_timeout", {63'd0, done}, 64'd1);
      @(posedge clk); #1;
    end
  endtask

  task automatic do1(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                     input logic [31:0] d, input logic retry);
    set_beat(0, wr, a, sz, d);
    run_seq(1, retry);
  endtask

  initial begin
    use3 = 1'b0; hsel = 1'b0; htrans = 2'd0; hwrite = 1'b0; hsize = 3'd2;
    hburst = 3'd0; haddr = '0; hwdata = '0; retry_req = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_val("rst_hready0", bus0.hready_out, 1);
    check_val("rst_hresp0", bus0.hresp, 0);
    check_val("rst_hrdata0", bus0.hrdata, 0);
    check_val("rst_hready3", bus3.hready_out, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // zero-wait write then read
    do1(1'b1, 32'h10, 3'd2, 32'hA5A5_0001, 1'b0);
    check_val("t1_wr_waits", q_waits[0], 0);
    check_val("t1_wr_resp", q_resp[0], 0);
    do1(1'b0, 32'h10, 3'd2, 32'h0, 1'b0);
    check_val("t1_rd_waits", q_waits[0], 0);
    check_val("t1_rd_data", q_rdata[0], 32'hA5A5_0001);
    check_val("t1_rd_resp", q_resp[0], 0);

    // byte and halfword lanes
    do1(1'b1, 32'h0, 3'd2, 32'h1122_3344, 1'b0);
    do1(1'b1, 32'h1, 3'd0, 32'h0000_BB00, 1'b0);
    do1(1'b1, 32'h2, 3'd1, 32'hCCDD_0000, 1'b0);
    do1(1'b0, 32'h0, 3'd2, 32'h0, 1'b0);
    check_val("t2_lanes", q_rdata[0], 32'hCCDD_BB44);

    // read in the data cycle of a write to the same word
    set_beat(0, 1'b1, 32'h14, 3'd2, 32'h55AA_55AA);
    set_beat(1, 1'b0, 32'h14, 3'd2, 32'h0);
    run_seq(2, 1'b0);
    check_val("raw_data", q_rdata[1], 32'h55AA_55AA);
    check_val("raw_waits", q_waits[1], 0);

    // last valid word
    do1(1'b1, 32'h3FC, 3'd2, 32'hFEED_C0DE, 1'b0);
    do1(1'b0, 32'h3FC, 3'd2, 32'h0, 1'b0);
    check_val("top_word", q_rdata[0], 32'hFEED_C0DE);
    check_val("top_resp", q_resp[0], 0);

    // IDLE and BUSY with a bad address are never accepted
    for (int t = 0; t < 2; t++) begin
      hsel = 1'b1; htrans = 2'(t); haddr = 32'h400; hwrite = 1'b0;
      @(posedge clk); #1;
      hsel = 1'b0; htrans = 2'd0;
      @(negedge clk);
      check_val("idle_busy_hready", obs_hready, 1);
      check_val("idle_busy_hresp", obs_hresp, 0);
      @(posedge clk); #1;
    end

    // error paths
    do1(1'b0, 32'h400, 3'd2, 32'h0, 1'b0);
    check_val("err_range_waits", q_waits[0], 1);
    check_val("err_range_wresp", q_wresp[0], 1);
    check_val("err_range_resp", q_resp[0], 1);
    do1(1'b1, 32'h2, 3'd2, 32'hDEAD_BEEF, 1'b0);
    check_val("err_align_waits", q_waits[0], 1);
    check_val("err_align_wresp", q_wresp[0], 1);
    check_val("err_align_resp", q_resp[0], 1);
    do1(1'b0, 32'h0, 3'd2, 32'h0, 1'b0);
    check_val("err_align_nowrite", q_rdata[0], 32'hCCDD_BB44);
    do1(1'b1, 32'h10, 3'd3, 32'hFFFF_FFFF, 1'b0);
    check_val("err_size_resp", q_resp[0], 1);
    do1(1'b0, 32'h10, 3'd2, 32'h0, 1'b0);
    check_val("err_size_nowrite", q_rdata[0], 32'hA5A5_0001);

    // retry, reissue, and error-over-retry priority
    do1(1'b1, 32'h8, 3'd2, 32'h1234_5678, 1'b0);
    do1(1'b1, 32'h8, 3'd2, 32'h0BAD_F00D, 1'b1);
    check_val("retry_waits", q_waits[0], 1);
    check_val("retry_wresp", q_wresp[0], 2);
    check_val("retry_resp", q_resp[0], 2);
    do1(1'b0, 32'h8, 3'd2, 32'h0, 1'b0);
    check_val("retry_nowrite", q_rdata[0], 32'h1234_5678);
    do1(1'b1, 32'h8, 3'd2, 32'h0BAD_F00D, 1'b0);
    check_val("reissue_resp", q_resp[0], 0);
    do1(1'b0, 32'h8, 3'd2, 32'h0, 1'b0);
    check_val("reissue_data", q_rdata[0], 32'h0BAD_F00D);
    do1(1'b0, 32'h400, 3'd2, 32'h0, 1'b1);
    check_val("err_over_retry", q_resp[0], 1);

    // three wait states, INCR4 write then read burst
    use3 = 1'b1;
    for (int b = 0; b < 4; b++) set_beat(b, 1'b1, 32'h20 + 32'(4*b), 3'd2, 32'h1000_0000 + 32'(b*17));
    run_seq(4, 1'b0);
    for (int b = 0; b < 4; b++) begin
      check_val("ws3_wr_waits", q_waits[b], 3);
      check_val("ws3_wr_wresp", q_wresp[b], 0);
      check_val("ws3_wr_resp", q_resp[b], 0);
    end
    for (int b = 0; b < 4; b++) set_beat(b, 1'b0, 32'h20 + 32'(4*b), 3'd2, 32'h0);
    run_seq(4, 1'b0);
    check_val("ws3_rd0", q_rdata[0], 32'h1000_0000);
    check_val("ws3_rd1", q_rdata[1], 32'h1000_0011);
    check_val("ws3_rd2", q_rdata[2], 32'h1000_0022);
    check_val("ws3_rd3", q_rdata[3], 32'h1000_0033);
    for (int b = 0; b < 4; b++) check_val("ws3_rd_waits", q_waits[b], 3);

    // reset during the wait state of a write
    do1(1'b1, 32'h40, 3'd2, 32'h600D_CAFE, 1'b0);
    hsel = 1'b1; htrans = 2'd2; haddr = 32'h40; hwrite = 1'b1; hsize = 3'd2;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'd0; hwdata = 32'hBAD0_BAD0;
    @(negedge clk);
    check_val("rst_mid_pre_hready", obs_hready, 0);
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_mid_hready", bus3.hready_out, 1);
    check_val("rst_mid_hresp", bus3.hresp, 0);
    check_val("rst_mid_hrdata", bus3.hrdata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do1(1'b0, 32'h40, 3'd2, 32'h0, 1'b0);
    check_val("rst_mid_nowrite", q_rdata[0], 32'h600D_CAFE);
    check_val("rst_mid_rd_waits", q_waits[0], 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
